// File: rtl/mem_sync_pkg.sv
// mem_sync_pkg: shared FSM state type and default geometry for mem_sync_xfer
package mem_sync_pkg;
  localparam int CHWIDTH_DEF   = 6;
  localparam int ADDRWIDTH_DEF = 17;
  localparam int BEATW_DEF     = 3;
  localparam int DATAWIDTH_DEF = 64;
  typedef enum logic [2:0] {
    IDLE,
    WB_RD,
    WB_CAP,
    WB_WR,
    AL_RD,
    AL_WAIT,
    DONE
  } state_e;
endpackage

// File: rtl/xfer_beat_ctr.sv
// xfer_beat_ctr: beat index within a row, with clear, increment and last-beat flag
module xfer_beat_ctr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] beat,
  output logic         last
);
  logic [W-1:0] beat_q, beat_d;
  // clear has priority so a new transfer always starts on beat 0
  always_comb beat_d = clr ? '0 : inc ? beat_q + 1'b1 : beat_q;
  // beat register, active-low synchronous reset
  always_ff @(posedge clk) beat_q <= !rst ? '0 : beat_d;
  assign beat = beat_q;
  assign last = &beat_q;
endmodule

// File: rtl/mem_sync_xfer.sv
// mem_sync_xfer: row writeback/allocate mover between cache and backing store; MEM_SYNC_XFER_STATS_EN adds transfer counters
module mem_sync_xfer
  import mem_sync_pkg::*;
#(
  parameter int CHWIDTH   = CHWIDTH_DEF,
  parameter int ADDRWIDTH = ADDRWIDTH_DEF,
  parameter int BEATW     = BEATW_DEF,
  parameter int DATAWIDTH = DATAWIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wb_req,
  input  logic                       al_req,
  input  logic [CHWIDTH-1:0]         cRowId,
  input  logic [ADDRWIDTH-1:0]       RowId,
  output logic                       sync,
  output logic                       busy,
  output logic [CHWIDTH+BEATW-1:0]   c_addr,
  output logic                       c_rd,
  output logic                       c_wr,
  output logic [DATAWIDTH-1:0]       c_wdata,
  input  logic [DATAWIDTH-1:0]       c_rdata,
  output logic [ADDRWIDTH+BEATW-1:0] m_addr,
  output logic                       m_valid,
  output logic                       m_wr,
  input  logic                       m_ready,
  output logic [DATAWIDTH-1:0]       m_wdata,
  input  logic                       m_rvalid,
  input  logic [DATAWIDTH-1:0]       m_rdata
`ifdef MEM_SYNC_XFER_STATS_EN
  ,
  output logic [15:0]                wb_cnt,
  output logic [15:0]                al_cnt
`endif
);
  state_e                 state_q, state_d;
  logic [CHWIDTH-1:0]     crow_q, crow_d;
  logic [ADDRWIDTH-1:0]   row_q, row_d;
  logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
  logic                   is_wb_q, is_wb_d;
  logic [BEATW-1:0]       beat;
  logic                   last, clr, inc;

  xfer_beat_ctr #(.W(BEATW)) u_beat (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .inc  (inc),
    .beat (beat),
    .last (last)
  );

  // next state and outputs; outputs are zero outside the states that drive them
  always_comb begin
    state_d = state_q;
    crow_d  = crow_q;
    row_d   = row_q;
    wdata_d = wdata_q;
    is_wb_d = is_wb_q;
    clr     = 1'b0;
    inc     = 1'b0;
    sync    = 1'b0;
    busy    = state_q != IDLE;
    c_addr  = '0;
    c_rd    = 1'b0;
    c_wr    = 1'b0;
    c_wdata = '0;
    m_addr  = '0;
    m_valid = 1'b0;
    m_wr    = 1'b0;
    m_wdata = '0;
    case (state_q)
      IDLE: begin
        if (wb_req || al_req) begin
          crow_d  = cRowId;
          row_d   = RowId;
          is_wb_d = wb_req;
          clr     = 1'b1;
          state_d = wb_req ? WB_RD : AL_RD;
        end
      end
      WB_RD: begin
        c_rd    = 1'b1;
        c_addr  = {crow_q, beat};
        state_d = WB_CAP;
      end
      WB_CAP: begin
        wdata_d = c_rdata;
        state_d = WB_WR;
      end
      WB_WR: begin
        m_valid = 1'b1;
        m_wr    = 1'b1;
        m_addr  = {row_q, beat};
        m_wdata = wdata_q;
        inc     = m_ready && !last;
        state_d = !m_ready ? WB_WR : last ? DONE : WB_RD;
      end
      AL_RD: begin
        m_valid = 1'b1;
        m_addr  = {row_q, beat};
        state_d = m_ready ? AL_WAIT : AL_RD;
      end
      AL_WAIT: begin
        c_wr    = m_rvalid;
        c_addr  = m_rvalid ? {crow_q, beat} : '0;
        c_wdata = m_rvalid ? m_rdata : '0;
        inc     = m_rvalid && !last;
        state_d = !m_rvalid ? AL_WAIT : last ? DONE : AL_RD;
      end
      DONE: begin
        sync    = 1'b1;
        clr     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // control and hold registers, active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      crow_q  <= '0;
      row_q   <= '0;
      wdata_q <= '0;
      is_wb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      crow_q  <= crow_d;
      row_q   <= row_d;
      wdata_q <= wdata_d;
      is_wb_q <= is_wb_d;
    end
  end

`ifdef MEM_SYNC_XFER_STATS_EN
  logic [15:0] wb_cnt_q, wb_cnt_d, al_cnt_q, al_cnt_d;
  // count completed transfers by type, saturating
  always_comb begin
    wb_cnt_d = (state_q == DONE && is_wb_q && !(&wb_cnt_q)) ? wb_cnt_q + 16'd1 : wb_cnt_q;
    al_cnt_d = (state_q == DONE && !is_wb_q && !(&al_cnt_q)) ? al_cnt_q + 16'd1 : al_cnt_q;
  end
  // counter registers, cleared by reset
  always_ff @(posedge clk) begin
    wb_cnt_q <= !rst ? '0 : wb_cnt_d;
    al_cnt_q <= !rst ? '0 : al_cnt_d;
  end
  assign wb_cnt = wb_cnt_q;
  assign al_cnt = al_cnt_q;
`endif
endmodule

// File: doc/mem_sync_xfer.md
MEM_SYNC_XFER -- requirements
Module: mem_sync_xfer

Interface
REQ-001 The block SHALL have parameter CHWIDTH, default 6, meaning log2 of cache row count.
REQ-002 The block SHALL have parameter ADDRWIDTH, default 17, meaning log2 of backing row count.
REQ-003 The block SHALL have parameter BEATW, default 3, meaning log2 of data beats per row.
REQ-004 The block SHALL have parameter DATAWIDTH, default 64, meaning width of one beat.
REQ-005 The block SHALL have one clock and a synchronous active-low reset, with ports as follows:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- wb_req  in  1  writeback request, level.
- al_req  in  1  allocate request, level.
- cRowId  in  CHWIDTH  cache row.
- RowId  in  ADDRWIDTH  backing row.
- sync  out  1  one-cycle completion pulse.
- busy  out  1  transfer in progress.
- c_addr  out  CHWIDTH+BEATW  cache word address.
- c_rd / c_wr  out  1  cache read/write strobes.
- c_wdata  out  DATAWIDTH  cache write data.
- c_rdata  in  DATAWIDTH  cache read data, valid the cycle after c_rd.
- m_addr  out  ADDRWIDTH+BEATW  backing word address.
- m_valid / m_wr  out  1  backing request valid / write-not-read.
- m_ready  in  1  backing accepts request.
- m_wdata  out  DATAWIDTH  backing write data.
- m_rvalid  in  1  backing read data valid.
- m_rdata  in  DATAWIDTH  backing read data.

Function
REQ-006 The FSM SHALL have states IDLE, WB_RD, WB_CAP, WB_WR, AL_RD, AL_WAIT and DONE.
REQ-007 In IDLE, wb_req=1 SHALL latch cRowId/RowId, clear the beat counter and go to WB_RD; else al_req=1 SHALL latch and go to AL_RD; when both are high, writeback wins and al_req is not consumed.
REQ-008 WB_RD SHALL assert c_rd with c_addr={cRowId_q,beat} for one cycle, then go to WB_CAP.
REQ-009 WB_CAP SHALL register c_rdata into the write-data hold register, then go to WB_WR.
REQ-010 WB_WR SHALL hold m_valid=1, m_wr=1, m_addr={RowId_q,beat} and m_wdata stable until m_ready=1; on acceptance it SHALL go to DONE if beat is all-ones, else increment beat and go to WB_RD.
REQ-011 AL_RD SHALL hold m_valid=1, m_wr=0 and m_addr until m_ready=1, then go to AL_WAIT.
REQ-012 AL_WAIT SHALL, on m_rvalid=1, assert c_wr=1 with c_addr={cRowId_q,beat} and c_wdata=m_rdata in the same cycle; it SHALL then go to DONE if this is the last beat, else increment beat and go to AL_RD.
REQ-013 DONE SHALL assert sync=1 for exactly one cycle, then go to IDLE.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 m_rvalid outside AL_WAIT SHALL be ignored.
REQ-016 With m_ready tied to 1, writeback SHALL take 3*2^BEATW cycles plus DONE, and allocate with 1-cycle rvalid SHALL take 2*2^BEATW cycles plus DONE.
REQ-017 Beat counter wrap from all-ones SHALL occur only via the DONE transition; wb_req, al_req, cRowId and RowId changes while busy SHALL be ignored.

Reset
REQ-018 rst=0 at a clock edge SHALL force IDLE, beat=0, and sync, busy, c_rd, c_wr, m_valid, m_wr=0 and all address/data outputs to 0, including mid-transfer; no sync pulse SHALL be emitted for an aborted transfer.

Configuration
REQ-019 With MEM_SYNC_XFER_STATS_EN defined, the block SHALL add outputs wb_cnt and al_cnt (16 bits each), incremented in DONE per completed transfer type, saturating at 16'hFFFF and cleared by reset.
REQ-020 Without MEM_SYNC_XFER_STATS_EN, these ports and counters SHALL NOT exist and behaviour SHALL be otherwise identical.

Structure
REQ-021 The package mem_sync_pkg SHALL hold the FSM state enum and the default CHWIDTH, ADDRWIDTH, BEATW and DATAWIDTH constants.
REQ-022 The beat counter SHALL be the sub-module xfer_beat_ctr, with clear, increment and last outputs.

Verification
REQ-023 wb_req=1, cRowId=5, RowId=0x1ABCD, m_ready=1, cache preloaded -> 8 backing writes to addrs 0xD5E68..0xD5E6F with matching data; sync is high on edge 25 after accept.
REQ-024 al_req=1, cRowId=63, RowId=0, rvalid 1 cycle after accept -> cache addrs 504..511 written with m_rdata; one sync pulse after 16 cycles.
REQ-025 wb_req and al_req high together -> writeback runs first; allocate starts in the cycle after DONE while al_req is held.
REQ-026 m_ready low for 4 cycles on beat 3 -> m_valid, m_addr and m_wdata hold stable; no beat is lost or duplicated.
REQ-027 rst=0 during beat 4 of allocate -> all outputs are 0 on the next cycle, no sync pulse, and a fresh request completes normally.
REQ-028 MEM_SYNC_XFER_STATS_EN: 3 writebacks and 2 allocates -> wb_cnt=3 and al_cnt=2.
